// File: rtl/hub_slot_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hub_slot_arbiter_if : cog-side and hub-memory-side bus bundle      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface hub_slot_arbiter_if #(
  parameter int COGS   = 8,
  parameter int ADDR_W = 16
);
  localparam int SLOT_W = $clog2(COGS);

  logic                   ena_bus;
  logic [COGS-1:0]        req;
  logic [COGS-1:0]        wr;
  logic [2*COGS-1:0]      sz;
  logic [ADDR_W*COGS-1:0] addr;
  logic [32*COGS-1:0]     wdata;

  logic                   mem_w;
  logic [3:0]             mem_wb;
  logic [ADDR_W-3:0]      mem_a;
  logic [31:0]            mem_d;
  logic [31:0]            mem_q;

  logic [COGS-1:0]        ack;
  logic [31:0]            rdata;
  logic [SLOT_W-1:0]      slot;

  modport slave (
    input  ena_bus, req, wr, sz, addr, wdata, mem_q,
    output mem_w, mem_wb, mem_a, mem_d, ack, rdata, slot
  );

  modport master (
    output ena_bus, req, wr, sz, addr, wdata, mem_q,
    input  mem_w, mem_wb, mem_a, mem_d, ack, rdata, slot
  );
endinterface
`default_nettype wire

// File: rtl/hub_slot_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hub_slot_arbiter : round-robin hub slot sequencer, 8 cogs          |
// | Optional lock bits on sz=11 when HUB_LOCK_EN is defined.           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hub_slot_arbiter #(
  parameter int COGS   = 8,
  parameter int ADDR_W = 16
) (
  input  wire logic          clk_cog,
  input  wire logic          res,
  hub_slot_arbiter_if.slave  bus
);

  localparam int         SLOT_W    = $clog2(COGS);
  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_WORD = 2'b01;
  localparam logic [1:0] c_SZ_LOCK = 2'b11;

  logic [ADDR_W-1:0] cog_addr  [COGS];
  logic [1:0]        cog_sz    [COGS];
  logic [31:0]       cog_wdata [COGS];

  genvar g;
  generate
    for (g = 0; g < COGS; g++) begin : g_unpack
      assign cog_addr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
      assign cog_sz[g]    = bus.sz[g*2 +: 2];
      assign cog_wdata[g] = bus.wdata[g*32 +: 32];
    end
  endgenerate

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              pend_v_q, pend_v_d;
  logic [SLOT_W-1:0] pend_cog_q, pend_cog_d;
  logic [1:0]        pend_sz_q, pend_sz_d;
  logic [1:0]        pend_lane_q, pend_lane_d;
  logic              pend_wr_q, pend_wr_d;
  logic [COGS-1:0]   ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              cur_req;
  logic              cur_wr;
  logic [1:0]        cur_sz;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic              cur_lock;
  logic              grant;

  assign cur_req   = bus.req[slot_q];
  assign cur_wr    = bus.wr[slot_q];
  assign cur_sz    = cog_sz[slot_q];
  assign cur_addr  = cog_addr[slot_q];
  assign cur_wdata = cog_wdata[slot_q];
  assign grant     = bus.ena_bus & cur_req;

`ifdef HUB_LOCK_EN
  logic [7:0] lock_q, lock_d;
  logic [2:0] pend_lid_q, pend_lid_d;
  assign cur_lock = (cur_sz == c_SZ_LOCK);
`else
  assign cur_lock = 1'b0;
`endif

  // Memory-side drive: purely combinational from the slot owner.
  always_comb begin
    bus.mem_wb = 4'b1111;
    bus.mem_d  = cur_wdata;
    case (cur_sz)
      c_SZ_BYTE: begin
        bus.mem_wb = 4'b0001 << cur_addr[1:0];
        bus.mem_d  = {4{cur_wdata[7:0]}};
      end
      c_SZ_WORD: begin
        bus.mem_wb = cur_addr[1] ? 4'b1100 : 4'b0011;
        bus.mem_d  = {2{cur_wdata[15:0]}};
      end
      default: begin
        bus.mem_wb = 4'b1111;
        bus.mem_d  = cur_wdata;
      end
    endcase
  end

  // The top half of the address space is ROM: the write is dropped, the ack is not.
  assign bus.mem_w = grant & cur_wr & ~cur_addr[ADDR_W-1] & ~cur_lock;
  assign bus.mem_a = cur_addr[ADDR_W-1:2];

  always_comb begin
    slot_d      = bus.ena_bus ? slot_q + 1'b1 : slot_q;
    pend_v_d    = grant;
    pend_cog_d  = pend_cog_q;
    pend_sz_d   = pend_sz_q;
    pend_lane_d = pend_lane_q;
    pend_wr_d   = pend_wr_q;
`ifdef HUB_LOCK_EN
    pend_lid_d  = pend_lid_q;
`endif
    if (grant) begin
      pend_cog_d  = slot_q;
      pend_sz_d   = cur_sz;
      pend_lane_d = cur_addr[1:0];
      pend_wr_d   = cur_wr;
`ifdef HUB_LOCK_EN
      pend_lid_d  = cur_addr[2:0];
`endif
    end
  end

  // Completion: one edge after the grant, independent of ena_bus.
  always_comb begin
    ack_d   = '0;
    rdata_d = rdata_q;
`ifdef HUB_LOCK_EN
    lock_d  = lock_q;
`endif
    if (pend_v_q) begin
      ack_d[pend_cog_q] = 1'b1;
      if (pend_wr_q) begin
        rdata_d = 32'h0;
      end else begin
        case (pend_sz_q)
          c_SZ_BYTE: begin
            case (pend_lane_q)
              2'd0:    rdata_d = {24'h0, bus.mem_q[7:0]};
              2'd1:    rdata_d = {24'h0, bus.mem_q[15:8]};
              2'd2:    rdata_d = {24'h0, bus.mem_q[23:16]};
              default: rdata_d = {24'h0, bus.mem_q[31:24]};
            endcase
          end
          c_SZ_WORD: rdata_d = pend_lane_q[1] ? {16'h0, bus.mem_q[31:16]}
                                              : {16'h0, bus.mem_q[15:0]};
          default:   rdata_d = bus.mem_q;
        endcase
      end
`ifdef HUB_LOCK_EN
      if (pend_sz_q == c_SZ_LOCK) begin
        rdata_d            = {31'h0, lock_q[pend_lid_q]};
        lock_d[pend_lid_q] = pend_wr_q;
      end
`endif
    end
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      slot_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_cog_q  <= '0;
      pend_sz_q   <= 2'b00;
      pend_lane_q <= 2'b00;
      pend_wr_q   <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= 32'h0;
`ifdef HUB_LOCK_EN
      lock_q      <= 8'h00;
      pend_lid_q  <= 3'd0;
`endif
    end else begin
      slot_q      <= slot_d;
      pend_v_q    <= pend_v_d;
      pend_cog_q  <= pend_cog_d;
      pend_sz_q   <= pend_sz_d;
      pend_lane_q <= pend_lane_d;
      pend_wr_q   <= pend_wr_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
`ifdef HUB_LOCK_EN
      lock_q      <= lock_d;
      pend_lid_q  <= pend_lid_d;
`endif
    end
  end

  assign bus.slot  = slot_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_hub_slot_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hub_slot_arbiter : directed bench with a registered hub memory  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_hub_slot_arbiter;

  logic clk_cog = 1'b0;
  logic res     = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   exp_slot = 0;

  hub_slot_arbiter_if #(.COGS(8), .ADDR_W(16)) bus ();

  hub_slot_arbiter #(.COGS(8), .ADDR_W(16)) dut (
    .clk_cog (clk_cog),
    .res     (res),
    .bus     (bus)
  );

  always #5 clk_cog = ~clk_cog;

  // Hub memory: synchronous read, byte-enabled write.
  logic [31:0] mem [0:16383];
  always @(posedge clk_cog) begin
    if (bus.mem_w) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wb[b]) mem[bus.mem_a][8*b +: 8] <= bus.mem_d[8*b +: 8];
    end
    bus.mem_q <= mem[bus.mem_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cog);
    if (res) exp_slot = 0;
    else if (bus.ena_bus) exp_slot = (exp_slot + 1) % 8;
    #1;
  endtask

  task automatic go_to_slot(input int n);
    for (int k = 0; k < 8 && exp_slot != n; k++) tick();
    chk("slot_wait", {29'h0, bus.slot}, n);
  endtask

  task automatic set_cog(input int c, input logic w, input logic [1:0] s,
                         input logic [15:0] a, input logic [31:0] d);
    bus.req[c]           = 1'b1;
    bus.wr[c]            = w;
    bus.sz[2*c +: 2]     = s;
    bus.addr[16*c +: 16] = a;
    bus.wdata[32*c +: 32] = d;
  endtask

  task automatic do_access(input int c, input logic w, input logic [1:0] s,
                           input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] exp_wb, input logic exp_w,
                           input logic [13:0] exp_a, input logic [31:0] exp_d,
                           input logic [31:0] exp_rd);
    set_cog(c, w, s, a, d);
    go_to_slot(c);
    chk("mem_w", bus.mem_w, exp_w);
    chk("mem_wb", bus.mem_wb, exp_wb);
    chk("mem_a", bus.mem_a, exp_a);
    chk("mem_d", bus.mem_d, exp_d);
    tick();
    chk("ack_early", bus.ack, 0);
    tick();
    chk("ack", bus.ack, 32'h1 << c);
    chk("rdata", bus.rdata, exp_rd);
    bus.req[c] = 1'b0;
    tick();
    chk("ack_clear", bus.ack, 0);
  endtask

  initial begin
    bus.ena_bus = 1'b0;
    bus.req     = '0;
    bus.wr      = '0;
    bus.sz      = '0;
    bus.addr    = '0;
    bus.wdata   = '0;

    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
    chk("rst_slot", {29'h0, bus.slot}, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);

    // Idle rotation
    bus.ena_bus = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_slot", {29'h0, bus.slot}, i % 8);
      chk("idle_ack", bus.ack, 0);
      chk("idle_mem_w", bus.mem_w, 0);
      tick();
    end

    // Cog 3 long write, then byte and word reads of the same long
    do_access(3, 1'b1, 2'b10, 16'h0104, 32'hDEADBEEF, 4'b1111, 1'b1, 14'h0041, 32'hDEADBEEF, 32'h0);
    do_access(3, 1'b0, 2'b00, 16'h0106, 32'h0, 4'b0100, 1'b0, 14'h0041, 32'h0, 32'h000000AD);
    do_access(3, 1'b0, 2'b01, 16'h0106, 32'h0, 4'b1100, 1'b0, 14'h0041, 32'h0, 32'h0000DEAD);

    // Word write / word read on another long
    do_access(2, 1'b1, 2'b01, 16'h0202, 32'h1234BEEF, 4'b1100, 1'b1, 14'h0080, 32'hBEEFBEEF, 32'h0);
    do_access(7, 1'b0, 2'b01, 16'h0202, 32'h0, 4'b1100, 1'b0, 14'h0080, 32'h0, 32'h0000BEEF);

    // Back-to-back grants: cog 0 then cog 1
    set_cog(0, 1'b0, 2'b10, 16'h0104, 32'h0);
    go_to_slot(0);
    set_cog(1, 1'b0, 2'b00, 16'h0107, 32'h0);
    chk("b2b_mem_a0", bus.mem_a, 14'h0041);
    tick();
    chk("b2b_mem_wb1", bus.mem_wb, 4'b1000);
    chk("b2b_ack_early", bus.ack, 0);
    tick();
    chk("b2b_ack0", bus.ack, 8'h01);
    chk("b2b_rdata0", bus.rdata, 32'hDEADBEEF);
    bus.req[0] = 1'b0;
    tick();
    chk("b2b_ack1", bus.ack, 8'h02);
    chk("b2b_rdata1", bus.rdata, 32'h000000DE);
    bus.req[1] = 1'b0;
    tick();
    chk("b2b_ack_clear", bus.ack, 0);

    // ROM write suppressed but acked
    do_access(5, 1'b1, 2'b00, 16'h9000, 32'h000000AA, 4'b0001, 1'b0, 14'h2400, 32'hAAAAAAAA, 32'h0);

    // ena_bus low on the completion edge
    set_cog(6, 1'b0, 2'b10, 16'h0104, 32'h0);
    go_to_slot(6);
    tick();
    bus.ena_bus = 1'b0;
    tick();
    chk("noena_ack", bus.ack, 8'h40);
    chk("noena_rdata", bus.rdata, 32'hDEADBEEF);
    chk("noena_slot", {29'h0, bus.slot}, 7);
    bus.req[6] = 1'b0;
    tick();
    chk("hold_slot", {29'h0, bus.slot}, 7);
    chk("hold_ack", bus.ack, 0);
    bus.ena_bus = 1'b1;

    // Reset on the edge after a cog 2 read grant
    set_cog(2, 1'b0, 2'b10, 16'h0104, 32'h0);
    go_to_slot(2);
    tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    bus.req[2] = 1'b0;
    chk("rstmid_ack", bus.ack, 0);
    chk("rstmid_slot", {29'h0, bus.slot}, 0);
    tick();
    chk("rstmid_ack2", bus.ack, 0);
    chk("rstmid_slot2", {29'h0, bus.slot}, 1);

`ifdef HUB_LOCK_EN
    do_access(4, 1'b1, 2'b11, 16'h0002, 32'h0, 4'b1111, 1'b0, 14'h0000, 32'h0, 32'h0);
    do_access(4, 1'b1, 2'b11, 16'h0002, 32'h0, 4'b1111, 1'b0, 14'h0000, 32'h0, 32'h1);
    do_access(4, 1'b0, 2'b11, 16'h0002, 32'h0, 4'b1111, 1'b0, 14'h0000, 32'h0, 32'h1);
    do_access(4, 1'b1, 2'b11, 16'h0002, 32'h0, 4'b1111, 1'b0, 14'h0000, 32'h0, 32'h0);
`else
    do_access(4, 1'b0, 2'b11, 16'h0104, 32'h0, 4'b1111, 1'b0, 14'h0041, 32'h0, 32'hDEADBEEF);
    do_access(4, 1'b1, 2'b11, 16'h0300, 32'h12345678, 4'b1111, 1'b1, 14'h00C0, 32'h12345678, 32'h0);
    do_access(4, 1'b0, 2'b10, 16'h0300, 32'h0, 4'b1111, 1'b0, 14'h00C0, 32'h0, 32'h12345678);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
